// File: rtl/sram_rw_arbiter_if.sv
// sram_rw_arbiter_if: two requester channels plus the in-order read response channel
interface sram_rw_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  a_valid, a_ready, a_we;
    logic [NUM_WMASKS-1:0] a_wmask;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  b_valid, b_ready, b_we;
    logic [NUM_WMASKS-1:0] b_wmask;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  rsp_valid, rsp_id;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output a_valid, a_we, a_wmask, a_addr, a_wdata,
        output b_valid, b_we, b_wmask, b_addr, b_wdata,
        input  a_ready, b_ready, rsp_valid, rsp_id, rsp_rdata
    );
    modport slave (
        input  a_valid, a_we, a_wmask, a_addr, a_wdata,
        input  b_valid, b_we, b_wmask, b_addr, b_wdata,
        output a_ready, b_ready, rsp_valid, rsp_id, rsp_rdata
    );
endinterface

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: round-robin A/B arbiter driving the RW port of a 1RW1R SRAM macro,
// with in-order read responses and an optional post-reset clear sweep.
module sram_rw_arbiter #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_rw_arbiter_if.slave      bus,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  last_b, grant_a, grant_b, acc, sel_b;
    logic [1:0]            rd_v, rd_id;
    logic                  req_we;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // A wins a conflict only when B was granted last; B takes whatever A does not
    assign grant_a     = bus.a_valid & (~bus.b_valid | last_b);
    assign grant_b     = bus.b_valid & ~grant_a;
    assign bus.a_ready = rst_n & (state == RUN) & grant_a;
    assign bus.b_ready = rst_n & (state == RUN) & grant_b;
    assign acc         = bus.a_ready | bus.b_ready;
    assign sel_b       = bus.b_ready;
    assign busy        = (state == CLEAR);

    always_comb begin
        req_we    = sel_b ? bus.b_we    : bus.a_we;
        req_wmask = sel_b ? bus.b_wmask : bus.a_wmask;
        req_addr  = sel_b ? bus.b_addr  : bus.a_addr;
        req_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr      <= '0;
            last_b        <= 1'b1;
            rd_v          <= '0;
            rd_id         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_rdata <= '0;
            sram_csb0     <= 1'b1;
            sram_web0     <= 1'b1;
            sram_wmask0   <= '0;
            sram_addr0    <= '0;
            sram_din0     <= '0;
        end else begin
            rd_v          <= {rd_v[0], acc & ~req_we};
            rd_id         <= {rd_id[0], sel_b};
            bus.rsp_valid <= rd_v[1];
            if (rd_v[1]) begin
                bus.rsp_id    <= rd_id[1];
                bus.rsp_rdata <= sram_dout0;
            end
            if (state == CLEAR) begin
                sram_csb0   <= 1'b0;
                sram_web0   <= 1'b0;
                sram_wmask0 <= '1;
                sram_din0   <= '0;
                sram_addr0  <= clr_addr;
                clr_addr    <= clr_addr + 1'b1;
                if (&clr_addr) state <= RUN;
            end else begin
                sram_csb0 <= ~acc;
                if (acc) begin
                    sram_web0   <= ~req_we;
                    sram_wmask0 <= req_wmask;
                    sram_addr0  <= req_addr;
                    sram_din0   <= req_wdata;
                    last_b      <= sel_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb_sram_rw_arbiter: vector table, directed corner sequences and random traffic against
// a behavioural macro and a word-level reference memory with a response scoreboard.
module tb_sram_rw_arbiter;
    localparam int WORDS = 512;

    typedef struct packed {
        logic       v, we;
        logic [3:0] m;
        logic [8:0] a;
        logic [31:0] d;
    } rq_t;
    typedef struct packed {
        rq_t  a, b;
        logic ra, rb;
    } vec_t;
    typedef struct {
        int          due;
        logic        id;
        logic [31:0] data;
    } exp_t;

    localparam rq_t NO = '0;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        busy, sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    sram_rw_arbiter_if bus ();

    sram_rw_arbiter #(.CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural macro: latch pins at posedge, write or read at the following negedge
    logic [31:0] mem [WORDS];
    bit          mem_init = 0;
    logic        c_csb = 1'b1, c_web = 1'b1;
    logic [3:0]  c_m;
    logic [8:0]  c_a;
    logic [31:0] c_d;
    always @(posedge clk) begin
        c_csb <= sram_csb0; c_web <= sram_web0; c_m <= sram_wmask0; c_a <= sram_addr0; c_d <= sram_din0;
    end
    always @(negedge clk) begin
        if (!mem_init) begin
            foreach (mem[i]) mem[i] = $urandom;
            mem_init = 1;
        end
        sram_dout0 <= 'x;
        if (c_csb === 1'b0 && c_web === 1'b0)
            for (int i = 0; i < 4; i++) if (c_m[i]) mem[c_a][8*i +: 8] = c_d[8*i +: 8];
        if (c_csb === 1'b0 && c_web === 1'b1) sram_dout0 <= mem[c_a];
    end

    // Reference: accepted requests applied to a plain word array in order; reads are due 3 negedges later
    logic [31:0] ref_mem [WORDS];
    exp_t        expq [$];
    int          cyc = 0, clear_left = 0, winner;
    bit          armed = 0, was_rst = 0, last_was_b = 1;
    logic        exp_csb = 1'b1, exp_web;
    logic [3:0]  exp_m;
    logic [8:0]  exp_a;
    logic [31:0] exp_d;
    rq_t         w;

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, 32'(clear_left != 0));
            chk("csb0", sram_csb0, exp_csb);
            if (!exp_csb) begin
                chk("web0", sram_web0, exp_web);
                chk("addr0", sram_addr0, exp_a);
                if (!exp_web) begin
                    chk("wmask0", sram_wmask0, exp_m);
                    chk("din0", sram_din0, exp_d);
                end
            end
            if (was_rst) begin
                chk("rst_web0", sram_web0, 1);
                chk("rst_addr0", sram_addr0, 0);
                chk("rst_din0", sram_din0, 0);
                chk("rst_wmask0", sram_wmask0, 0);
                chk("rst_rsp_id", bus.rsp_id, 0);
                chk("rst_rsp_rdata", bus.rsp_rdata, 0);
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_id", bus.rsp_id, expq[0].id);
                chk("rsp_rdata", bus.rsp_rdata, expq[0].data);
                void'(expq.pop_front());
            end else chk("no_rsp", bus.rsp_valid, 0);
        end
        was_rst = 0;
        exp_csb = 1'b1;
        if (!rst_n) begin
            chk("rst_a_ready", bus.a_ready, 0);
            chk("rst_b_ready", bus.b_ready, 0);
            expq.delete();
            foreach (ref_mem[i]) ref_mem[i] = '0;
            clear_left = WORDS;
            last_was_b = 1;
            armed = 1;
            was_rst = 1;
        end else if (armed && clear_left > 0) begin
            chk("clr_a_ready", bus.a_ready, 0);
            chk("clr_b_ready", bus.b_ready, 0);
            exp_csb = 1'b0; exp_web = 1'b0; exp_m = 4'hF; exp_d = '0;
            exp_a = 9'(WORDS - clear_left);
            clear_left--;
        end else if (armed) begin
            if (bus.a_valid && bus.b_valid) winner = last_was_b ? 1 : 2;
            else if (bus.a_valid) winner = 1;
            else if (bus.b_valid) winner = 2;
            else winner = 0;
            chk("a_ready", bus.a_ready, 32'(winner == 1));
            chk("b_ready", bus.b_ready, 32'(winner == 2));
            if (winner != 0) begin
                w = (winner == 2) ? '{bus.b_valid, bus.b_we, bus.b_wmask, bus.b_addr, bus.b_wdata}
                                  : '{bus.a_valid, bus.a_we, bus.a_wmask, bus.a_addr, bus.a_wdata};
                last_was_b = (winner == 2);
                exp_csb = 1'b0; exp_web = ~w.we; exp_m = w.m; exp_a = w.a; exp_d = w.d;
                if (w.we) begin
                    for (int i = 0; i < 4; i++) if (w.m[i]) ref_mem[w.a][8*i +: 8] = w.d[8*i +: 8];
                end else expq.push_back('{cyc + 3, logic'(winner == 2), ref_mem[w.a]});
            end
        end
        cyc++;
    end

    function automatic rq_t wr(logic [8:0] a, logic [3:0] m, logic [31:0] d);
        return '{1'b1, 1'b1, m, a, d};
    endfunction
    function automatic rq_t rd(logic [8:0] a);
        return '{1'b1, 1'b0, 4'h0, a, 32'h0};
    endfunction

    task automatic drive(rq_t a, rq_t b);
        bus.a_valid = a.v; bus.a_we = a.we; bus.a_wmask = a.m; bus.a_addr = a.a; bus.a_wdata = a.d;
        bus.b_valid = b.v; bus.b_we = b.we; bus.b_wmask = b.m; bus.b_addr = b.a; bus.b_wdata = b.d;
    endtask

    task automatic step(rq_t a, rq_t b);
        @(posedge clk);
        #1 drive(a, b);
    endtask

    vec_t tbl [14];
    rq_t  ra, rb;
    bit   a_hs, b_hs;

    initial begin
        tbl[0]  = '{wr(9'd5, 4'hF, 32'hDEADBEEF), NO, 1'b1, 1'b0};
        tbl[1]  = '{NO, wr(9'd5, 4'h1, 32'h000000AA), 1'b0, 1'b1};
        tbl[2]  = '{rd(9'd5), NO, 1'b1, 1'b0};
        tbl[3]  = '{NO, NO, 1'b0, 1'b0};
        tbl[4]  = '{wr(9'd9, 4'hF, 32'h12345678), NO, 1'b1, 1'b0};
        tbl[5]  = '{NO, rd(9'd9), 1'b0, 1'b1};
        tbl[6]  = '{rd(9'd0), rd(9'd255), 1'b1, 1'b0};
        tbl[7]  = '{rd(9'd511), rd(9'd255), 1'b0, 1'b1};
        tbl[8]  = '{rd(9'd511), NO, 1'b1, 1'b0};
        tbl[9]  = '{wr(9'd1, 4'h3, 32'hCAFEF00D), wr(9'd2, 4'hC, 32'h0BADC0DE), 1'b0, 1'b1};
        tbl[10] = '{wr(9'd1, 4'h3, 32'hCAFEF00D), NO, 1'b1, 1'b0};
        tbl[11] = '{rd(9'd1), rd(9'd2), 1'b0, 1'b1};
        tbl[12] = '{rd(9'd1), NO, 1'b1, 1'b0};
        tbl[13] = '{NO, rd(9'd2), 1'b0, 1'b1};

        drive(NO, NO);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (WORDS) step(NO, NO);

        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].b);
            #2;
            chk($sformatf("vec%0d_a_ready", i), bus.a_ready, tbl[i].ra);
            chk($sformatf("vec%0d_b_ready", i), bus.b_ready, tbl[i].rb);
        end

        // Both requesters hold reads: grants must alternate starting with A
        for (int k = 0; k < 8; k++) begin
            step(rd(9'd5), rd(9'd9));
            #2;
            chk($sformatf("alt%0d_a_ready", k), bus.a_ready, 32'(k % 2 == 0));
            chk($sformatf("alt%0d_b_ready", k), bus.b_ready, 32'(k % 2 == 1));
        end
        step(NO, NO);

        a_hs = 1; b_hs = 1; ra = NO; rb = NO;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            if (!ra.v || a_hs) begin
                ra.v = ($urandom_range(0, 9) < 6); ra.we = 1'($urandom_range(0, 1));
                ra.m = 4'($urandom); ra.a = 9'($urandom_range(0, 15)); ra.d = $urandom;
            end
            if (!rb.v || b_hs) begin
                rb.v = ($urandom_range(0, 9) < 6); rb.we = 1'($urandom_range(0, 1));
                rb.m = 4'($urandom); rb.a = 9'($urandom_range(0, 15)); rb.d = $urandom;
            end
            drive(ra, rb);
            #2;
            a_hs = bus.a_valid & bus.a_ready;
            b_hs = bus.b_valid & bus.b_ready;
        end
        step(NO, NO);
        repeat (4) step(NO, NO);

        // Reset one cycle after a read accept: that read must never respond
        step(rd(9'd5), NO);
        #2 chk("pre_rst_a_ready", bus.a_ready, 1);
        @(posedge clk);
        #1 drive(NO, NO);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (WORDS) step(NO, NO);
        step(rd(9'd5), NO);
        step(NO, NO);
        repeat (5) step(NO, NO);

        chk("queue_drained", 32'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
